// File: rtl/hazard_forward_ctrl_pkg.sv
// Shared constants for the hazard/forwarding controller: forward-mux encodings and
// multi-cycle FSM state encoding.
package hazard_forward_ctrl_pkg;

  localparam logic [1:0] FWD_REGFILE = 2'b00;
  localparam logic [1:0] FWD_EXMEM   = 2'b10;
  localparam logic [1:0] FWD_MEMWB   = 2'b01;

  // Wide enough for MC_STALL-2 with MC_STALL up to 15
  localparam int unsigned MC_CNT_W = 4;

  typedef enum logic [1:0] {
    MC_IDLE    = 2'b00,
    MC_BUSY    = 2'b01,
    MC_RELEASE = 2'b10
  } mc_state_e;

endpackage

// File: rtl/hazard_forward_ctrl_fwd_sel.sv
// Per-operand forward select: EX/MEM result beats MEM/WB result, x0 is never forwarded.
module hazard_forward_ctrl_fwd_sel
  import hazard_forward_ctrl_pkg::*;
(
  input  logic [4:0] i_rs,
  input  logic [4:0] i_exmem_rd,
  input  logic       i_exmem_regwrite,
  input  logic [4:0] i_memwb_rd,
  input  logic       i_memwb_regwrite,
  output logic [1:0] o_sel
);

  always_comb begin
    o_sel = FWD_REGFILE;
    if (i_exmem_regwrite && (i_exmem_rd != 5'd0) && (i_exmem_rd == i_rs)) begin
      o_sel = FWD_EXMEM;
    end else if (i_memwb_regwrite && (i_memwb_rd != 5'd0) && (i_memwb_rd == i_rs)) begin
      o_sel = FWD_MEMWB;
    end
  end

endmodule

// File: rtl/hazard_forward_ctrl.sv
// Pipeline hazard controller: operand forwarding, load-use stall, fixed-latency
// multi-cycle EX sequencing, branch flush and saturating event counters.
module hazard_forward_ctrl
  import hazard_forward_ctrl_pkg::*;
#(
  parameter int unsigned MC_STALL = 3,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       ifid_rs1,
  input  logic [4:0]       ifid_rs2,
  input  logic [4:0]       idex_rs1,
  input  logic [4:0]       idex_rs2,
  input  logic [4:0]       idex_rd,
  input  logic             idex_memread,
  input  logic             mc_start,
  input  logic [4:0]       exmem_rd,
  input  logic             exmem_regwrite,
  input  logic [4:0]       memwb_rd,
  input  logic             memwb_regwrite,
  input  logic             branch_taken,
  output logic [1:0]       forward_a_sel,
  output logic [1:0]       forward_b_sel,
  output logic             pc_hold,
  output logic             ifid_hold,
  output logic             idex_hold,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             exmem_bubble,
  output logic             mc_busy,
  output logic [CNT_W-1:0] lu_stall_cnt,
  output logic [CNT_W-1:0] mc_stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [MC_CNT_W-1:0] McLoad = MC_CNT_W'(MC_STALL - 2);
  localparam logic [CNT_W-1:0]    CntMax = '1;
  localparam logic [CNT_W-1:0]    CntOne = CNT_W'(1);

  mc_state_e           r_state, w_state_nxt;
  logic [MC_CNT_W-1:0] r_mc_cnt, w_mc_cnt_nxt;
  logic [CNT_W-1:0]    r_lu_cnt, r_mc_stall_cnt, r_flush_cnt;
  logic                w_flush, w_mc_req, w_mc_stall, w_lu, w_lu_stall;

  hazard_forward_ctrl_fwd_sel u_fwd_a (
    .i_rs             (idex_rs1),
    .i_exmem_rd       (exmem_rd),
    .i_exmem_regwrite (exmem_regwrite),
    .i_memwb_rd       (memwb_rd),
    .i_memwb_regwrite (memwb_regwrite),
    .o_sel            (forward_a_sel)
  );

  hazard_forward_ctrl_fwd_sel u_fwd_b (
    .i_rs             (idex_rs2),
    .i_exmem_rd       (exmem_rd),
    .i_exmem_regwrite (exmem_regwrite),
    .i_memwb_rd       (memwb_rd),
    .i_memwb_regwrite (memwb_regwrite),
    .o_sel            (forward_b_sel)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= MC_IDLE;
      r_mc_cnt <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_mc_cnt <= w_mc_cnt_nxt;
    end
  end

  // A flush in the start cycle cancels the op, so the FSM stays idle
  always_comb begin
    w_state_nxt  = r_state;
    w_mc_cnt_nxt = r_mc_cnt;
    case (r_state)
      MC_IDLE: begin
        if (mc_start && !branch_taken) begin
          w_state_nxt  = MC_BUSY;
          w_mc_cnt_nxt = McLoad;
        end
      end
      MC_BUSY: begin
        if (r_mc_cnt == '0) w_state_nxt = MC_RELEASE;
        else                w_mc_cnt_nxt = r_mc_cnt - 1'b1;
      end
      MC_RELEASE: w_state_nxt = MC_IDLE;
      default:    w_state_nxt = MC_IDLE;
    endcase
  end

  // Priority: flush > multi-cycle stall > load-use; everything forced low in reset
  assign w_flush    = rst_n & branch_taken;
  assign w_mc_req   = (r_state == MC_BUSY) | ((r_state == MC_IDLE) & mc_start);
  assign w_mc_stall = rst_n & w_mc_req & ~branch_taken;
  assign w_lu       = idex_memread & (idex_rd != 5'd0) &
                      ((idex_rd == ifid_rs1) | (idex_rd == ifid_rs2));
  assign w_lu_stall = rst_n & w_lu & ~branch_taken & ~w_mc_stall;

  always_comb begin
    pc_hold      = w_mc_stall | w_lu_stall;
    ifid_hold    = w_mc_stall | w_lu_stall;
    idex_hold    = w_mc_stall;
    ifid_flush   = w_flush;
    idex_bubble  = w_flush | w_lu_stall;
    exmem_bubble = w_mc_stall;
    mc_busy      = (r_state == MC_BUSY) | (r_state == MC_RELEASE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lu_cnt       <= '0;
      r_mc_stall_cnt <= '0;
      r_flush_cnt    <= '0;
    end else begin
      if (w_lu_stall && (r_lu_cnt != CntMax))       r_lu_cnt       <= r_lu_cnt + CntOne;
      if (w_mc_stall && (r_mc_stall_cnt != CntMax)) r_mc_stall_cnt <= r_mc_stall_cnt + CntOne;
      if (w_flush && (r_flush_cnt != CntMax))       r_flush_cnt    <= r_flush_cnt + CntOne;
    end
  end

  assign lu_stall_cnt = r_lu_cnt;
  assign mc_stall_cnt = r_mc_stall_cnt;
  assign flush_cnt    = r_flush_cnt;

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// Bench for hazard_forward_ctrl: directed steps plus random traffic against a cycle-level
// reference model; a 2-bit-counter instance exercises saturation.
module tb_hazard_forward_ctrl;

  localparam int unsigned McStall = 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] ifid_rs1, ifid_rs2, idex_rs1, idex_rs2, idex_rd, exmem_rd, memwb_rd;
  logic       idex_memread, mc_start, exmem_regwrite, memwb_regwrite, branch_taken;

  logic [1:0]  forward_a_sel, forward_b_sel;
  logic        pc_hold, ifid_hold, idex_hold, ifid_flush, idex_bubble, exmem_bubble, mc_busy;
  logic [15:0] lu_stall_cnt, mc_stall_cnt, flush_cnt;

  logic [1:0]  s_fa, s_fb;
  logic        s_pch, s_ifh, s_idh, s_iff, s_idb, s_exb, s_busy;
  logic [1:0]  s_lu_cnt, s_mc_cnt, s_fl_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model state: stall cycles still owed, release pending, raw event counts
  int m_left, m_lu, m_mc, m_fl;
  bit m_rel;
  bit e_mcs, e_lue;

  always #5 clk = ~clk;

  hazard_forward_ctrl #(.MC_STALL(McStall), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .ifid_rs1(ifid_rs1), .ifid_rs2(ifid_rs2),
    .idex_rs1(idex_rs1), .idex_rs2(idex_rs2), .idex_rd(idex_rd),
    .idex_memread(idex_memread), .mc_start(mc_start), .exmem_rd(exmem_rd),
    .exmem_regwrite(exmem_regwrite), .memwb_rd(memwb_rd), .memwb_regwrite(memwb_regwrite),
    .branch_taken(branch_taken), .forward_a_sel(forward_a_sel),
    .forward_b_sel(forward_b_sel), .pc_hold(pc_hold), .ifid_hold(ifid_hold),
    .idex_hold(idex_hold), .ifid_flush(ifid_flush), .idex_bubble(idex_bubble),
    .exmem_bubble(exmem_bubble), .mc_busy(mc_busy), .lu_stall_cnt(lu_stall_cnt),
    .mc_stall_cnt(mc_stall_cnt), .flush_cnt(flush_cnt)
  );

  hazard_forward_ctrl #(.MC_STALL(McStall), .CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .ifid_rs1(ifid_rs1), .ifid_rs2(ifid_rs2),
    .idex_rs1(idex_rs1), .idex_rs2(idex_rs2), .idex_rd(idex_rd),
    .idex_memread(idex_memread), .mc_start(mc_start), .exmem_rd(exmem_rd),
    .exmem_regwrite(exmem_regwrite), .memwb_rd(memwb_rd), .memwb_regwrite(memwb_regwrite),
    .branch_taken(branch_taken), .forward_a_sel(s_fa), .forward_b_sel(s_fb),
    .pc_hold(s_pch), .ifid_hold(s_ifh), .idex_hold(s_idh), .ifid_flush(s_iff),
    .idex_bubble(s_idb), .exmem_bubble(s_exb), .mc_busy(s_busy),
    .lu_stall_cnt(s_lu_cnt), .mc_stall_cnt(s_mc_cnt), .flush_cnt(s_fl_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] fwd_ref(input logic [4:0] rs);
    if (exmem_regwrite && exmem_rd != 0 && exmem_rd == rs) return 32'd2;
    if (memwb_regwrite && memwb_rd != 0 && memwb_rd == rs) return 32'd1;
    return 32'd0;
  endfunction

  function automatic logic [31:0] sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic model_reset();
    m_left = 0; m_rel = 0; m_lu = 0; m_mc = 0; m_fl = 0;
  endtask

  task automatic all_idle();
    ifid_rs1 = 0; ifid_rs2 = 0; idex_rs1 = 0; idex_rs2 = 0; idex_rd = 0; exmem_rd = 0;
    memwb_rd = 0; idex_memread = 0; mc_start = 0; exmem_regwrite = 0; memwb_regwrite = 0;
    branch_taken = 0;
  endtask

  // Negedge: compare every output against the model
  task automatic step_check(input string tag);
    bit idle, lu;
    @(negedge clk);
    idle  = (m_left == 0) && !m_rel;
    e_mcs = !branch_taken && ((m_left > 0) || (idle && mc_start));
    lu    = idex_memread && idex_rd != 0 && (idex_rd == ifid_rs1 || idex_rd == ifid_rs2);
    e_lue = lu && !branch_taken && !e_mcs;
    chk({tag, ".fa"}, forward_a_sel, fwd_ref(idex_rs1));
    chk({tag, ".fb"}, forward_b_sel, fwd_ref(idex_rs2));
    chk({tag, ".pc_hold"}, pc_hold, e_mcs | e_lue);
    chk({tag, ".ifid_hold"}, ifid_hold, e_mcs | e_lue);
    chk({tag, ".idex_hold"}, idex_hold, e_mcs);
    chk({tag, ".ifid_flush"}, ifid_flush, branch_taken);
    chk({tag, ".idex_bubble"}, idex_bubble, branch_taken | e_lue);
    chk({tag, ".exmem_bubble"}, exmem_bubble, e_mcs);
    chk({tag, ".mc_busy"}, mc_busy, (m_left > 0) || m_rel);
    chk({tag, ".lu_cnt"}, lu_stall_cnt, sat(m_lu, 65535));
    chk({tag, ".mc_cnt"}, mc_stall_cnt, sat(m_mc, 65535));
    chk({tag, ".fl_cnt"}, flush_cnt, sat(m_fl, 65535));
    chk({tag, ".sat_lu"}, s_lu_cnt, sat(m_lu, 3));
    chk({tag, ".sat_mc"}, s_mc_cnt, sat(m_mc, 3));
    chk({tag, ".sat_fl"}, s_fl_cnt, sat(m_fl, 3));
  endtask

  // Posedge: advance the model with the decisions made in step_check
  task automatic step_clock();
    bit idle;
    @(posedge clk);
    idle = (m_left == 0) && !m_rel;
    if (e_lue) m_lu++;
    if (e_mcs) m_mc++;
    if (branch_taken) m_fl++;
    if (idle && mc_start && !branch_taken) m_left = McStall - 1;
    else if (m_left > 0) begin
      m_left--;
      if (m_left == 0) m_rel = 1;
    end else if (m_rel) m_rel = 0;
    #1;
  endtask

  task automatic step(input string tag);
    step_check(tag);
    step_clock();
  endtask

  initial begin
    rst_n = 1'b0;
    all_idle();
    model_reset();
    #2;
    chk("rst.pc_hold", pc_hold, 0);
    chk("rst.mc_busy", mc_busy, 0);
    chk("rst.lu_cnt", lu_stall_cnt, 0);
    mc_start = 1; branch_taken = 1; #1;
    chk("rst.gate_hold", idex_hold, 0);
    chk("rst.gate_flush", ifid_flush, 0);
    all_idle();
    #9 rst_n = 1'b1;
    step("idle");

    // Forwarding: double match, then MEM/WB only, then x0
    exmem_rd = 5; exmem_regwrite = 1; memwb_rd = 5; memwb_regwrite = 1;
    idex_rs1 = 5; idex_rs2 = 6; #1;
    chk("fwd.a_exmem", forward_a_sel, 2'b10);
    chk("fwd.b_none", forward_b_sel, 2'b00);
    step("fwd1");
    exmem_regwrite = 0; #1;
    chk("fwd.a_memwb", forward_a_sel, 2'b01);
    step("fwd2");
    exmem_rd = 0; exmem_regwrite = 1; memwb_regwrite = 0; idex_rs1 = 0; #1;
    chk("fwd.x0", forward_a_sel, 2'b00);
    step("fwd3");
    all_idle();

    // Load-use: one stall cycle, then the load has moved on
    idex_memread = 1; idex_rd = 7; ifid_rs2 = 7;
    step_check("lu0");
    chk("lu.pc_hold", pc_hold, 1);
    chk("lu.bubble", idex_bubble, 1);
    step_clock();
    idex_memread = 0;
    step("lu1");
    chk("lu.cnt", lu_stall_cnt, 1);
    all_idle();

    // Multi-cycle op held for MC_STALL+1 cycles
    mc_start = 1;
    for (int c = 0; c <= int'(McStall); c++) begin
      step_check($sformatf("mc%0d", c));
      chk($sformatf("mc%0d.hold", c), idex_hold, c < int'(McStall));
      chk($sformatf("mc%0d.busy", c), mc_busy, c >= 1);
      step_clock();
    end
    mc_start = 0;
    step("mc_idle");
    chk("mc.cnt", mc_stall_cnt, McStall);
    chk("mc.busy_end", mc_busy, 0);

    // Flush and mc_start in the same slot: flush wins
    mc_start = 1; branch_taken = 1;
    step_check("fl0");
    chk("fl.flush", ifid_flush, 1);
    chk("fl.hold", pc_hold, 0);
    step_clock();
    all_idle();
    step("fl1");
    chk("fl.busy", mc_busy, 0);
    chk("fl.cnt", flush_cnt, 1);

    // Saturation of the 2-bit instance under sustained load-use
    idex_memread = 1; idex_rd = 3; ifid_rs1 = 3;
    for (int i = 0; i < 5; i++) step("sat");
    chk("sat.lu", s_lu_cnt, 2'd3);
    all_idle();

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      ifid_rs1 = 5'($urandom_range(0, 3)); ifid_rs2 = 5'($urandom_range(0, 3));
      idex_rs1 = 5'($urandom_range(0, 3)); idex_rs2 = 5'($urandom_range(0, 3));
      idex_rd  = 5'($urandom_range(0, 3)); exmem_rd = 5'($urandom_range(0, 3));
      memwb_rd = 5'($urandom_range(0, 3));
      idex_memread   = ($urandom_range(0, 2) == 0);
      exmem_regwrite = $urandom_range(0, 1) != 0;
      memwb_regwrite = $urandom_range(0, 1) != 0;
      mc_start       = ($urandom_range(0, 7) == 0);
      branch_taken   = ($urandom_range(0, 9) == 0);
      step("rnd");
    end
    all_idle();

    // Asynchronous reset in the middle of a multi-cycle sequence
    mc_start = 1;
    step("rb0");
    step("rb1");
    #2 rst_n = 1'b0;
    #1;
    chk("rstm.pc_hold", pc_hold, 0);
    chk("rstm.idex_hold", idex_hold, 0);
    chk("rstm.exmem_bubble", exmem_bubble, 0);
    chk("rstm.busy", mc_busy, 0);
    chk("rstm.lu_cnt", lu_stall_cnt, 0);
    chk("rstm.mc_cnt", mc_stall_cnt, 0);
    chk("rstm.fl_cnt", flush_cnt, 0);
    mc_start = 0;
    #10 rst_n = 1'b1;
    model_reset();
    step("post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_forward_ctrl.md
Name: hazard_forward_ctrl

Overview:
Pipeline hazard controller for the 5-stage RISC-V core feeding the FFT/IFFT datapath. It generates the 2-bit operand-forwarding selects for the EX-stage forward muxes (operands A and B), and sequences load-use stalls, fixed-latency multi-cycle EX ops (butterfly multiply) and branch flushes. It sits beside the ID/EX and EX/MEM registers and drives their hold and bubble controls.

Parameters:
MC_STALL, 3, extra EX cycles a multi-cycle op needs; legal range 2..15.
CNT_W, 16, width of the saturating performance counters.

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous active-low reset
ifid_rs1  in  5  rs1 of the instruction in ID
ifid_rs2  in  5  rs2 of the instruction in ID
idex_rs1  in  5  rs1 of the instruction in EX
idex_rs2  in  5  rs2 of the instruction in EX
idex_rd  in  5  rd of the instruction in EX
idex_memread  in  1  EX instruction is a load
mc_start  in  1  EX instruction is a multi-cycle op
exmem_rd  in  5  rd in MEM
exmem_regwrite  in  1  MEM instruction writes rd
memwb_rd  in  5  rd in WB
memwb_regwrite  in  1  WB instruction writes rd
branch_taken  in  1  taken branch/jump resolved in EX
forward_a_sel  out  2  operand A mux select
forward_b_sel  out  2  operand B mux select
pc_hold  out  1  freeze the PC
ifid_hold  out  1  freeze IF/ID
idex_hold  out  1  freeze ID/EX
ifid_flush  out  1  zero IF/ID
idex_bubble  out  1  load a NOP into ID/EX
exmem_bubble  out  1  load a NOP into EX/MEM
mc_busy  out  1  multi-cycle sequence active
lu_stall_cnt  out  CNT_W  load-use stall cycles
mc_stall_cnt  out  CNT_W  multi-cycle stall cycles
flush_cnt  out  CNT_W  flush events

Behaviour:
- Reset (asynchronous, rst_n=0): FSM=IDLE, down-counter=0, all three counters=0. All hold, flush and bubble outputs are 0 while in reset. Forward selects stay combinational.
- Forward select encoding: 2'b00 = register file, 2'b10 = EX/MEM result, 2'b01 = MEM/WB result. 2'b11 is never driven.
- forward_a_sel (combinational, zero latency):
  - 10 if exmem_regwrite and exmem_rd!=0 and exmem_rd==idex_rs1.
  - Else 01 if memwb_regwrite and memwb_rd!=0 and memwb_rd==idex_rs1.
  - Else 00.
  - EX/MEM beats MEM/WB on a double match. x0 is never forwarded.
- forward_b_sel: same rules using idex_rs2.
- Load-use hazard: lu = idex_memread and idex_rd!=0 and (idex_rd==ifid_rs1 or idex_rd==ifid_rs2).
  - On lu: pc_hold=1, ifid_hold=1, idex_bubble=1 for exactly one cycle.
  - On the next cycle the load has moved to MEM, so lu drops on its own.
- Multi-cycle FSM, states IDLE, BUSY, RELEASE:
  - IDLE with mc_start=1: drive pc_hold, ifid_hold, idex_hold and exmem_bubble this cycle. Load counter with MC_STALL-2. Go to BUSY.
  - BUSY: drive the same four outputs and mc_busy=1. If counter==0 go to RELEASE, else decrement.
  - RELEASE: no stall, mc_busy=1. The op leaves EX at this edge. mc_start is ignored because it is still high from the same instruction. Go to IDLE.
  - Total: MC_STALL stall cycles; the op occupies EX for MC_STALL+1 cycles. The mc unit latches its operands in the start cycle.
  - mc_start is ignored in BUSY and RELEASE.
- Branch flush: branch_taken=1 gives ifid_flush=1 and idex_bubble=1 for that cycle, with no hold.
- Priority: flush > multi-cycle stall > load-use. mc_start and branch_taken describe the same EX slot and are mutually exclusive; if both are high, the flush wins and the FSM stays in IDLE.
- Counters increment by 1 per qualifying cycle and saturate at all-ones, no wrap:
  - lu_stall_cnt: cycles where the load-use stall is actually applied.
  - mc_stall_cnt: cycles with mc stall asserted.
  - flush_cnt: cycles with branch_taken=1.
- Reset mid-sequence: the FSM returns to IDLE immediately and all holds deassert asynchronously.

Decomposition:
- Shared include define.v gets these constants: FWD_REGFILE=2'b00, FWD_EXMEM=2'b10, FWD_MEMWB=2'b01, and the FSM encodings MC_IDLE/MC_BUSY/MC_RELEASE.
- One natural sub-module, fwd_sel: the combinational per-operand comparator producing one 2-bit select. It is instantiated twice, once for rs1 and once for rs2.
- The FSM, hazard priority logic and counters stay in the top module.

Test Plan:
- exmem_rd=5, exmem_regwrite=1, memwb_rd=5, memwb_regwrite=1, idex_rs1=5, idex_rs2=6 -> forward_a_sel=10, forward_b_sel=00. Then exmem_regwrite=0 -> forward_a_sel=01.
- exmem_rd=0, exmem_regwrite=1, idex_rs1=0 -> forward_a_sel=00 (x0 never forwarded).
- idex_memread=1, idex_rd=7, ifid_rs2=7 -> pc_hold, ifid_hold and idex_bubble high for exactly 1 cycle; lu_stall_cnt goes 0->1.
- MC_STALL=3, mc_start held high for 4 cycles -> holds and exmem_bubble high for cycles 0-2, RELEASE at cycle 3 with mc_busy=1 and no hold, IDLE at cycle 4; mc_stall_cnt=3 and there is no retrigger.
- branch_taken=1 together with mc_start=1 -> ifid_flush=1, idex_bubble=1, no hold, FSM stays IDLE; flush_cnt=1.
- rst_n pulsed low in BUSY -> holds drop asynchronously, FSM=IDLE, all counters=0. Separately, preload lu_stall_cnt to 16'hFFFF and trigger load-use -> it stays 16'hFFFF.
